dvp_gray_capture: RTL and testbench

Front-end stage that feeds the fast median filter. Accepts a DVP camera byte stream (RGB565, two bytes per pixel) already synchronised to sclk, drops a configurable number of start-up frames, and converts each pixel to 8-bit luma. Output drives the filter's din / data_valuable / vsync inputs directly.

---
 rtl/dvp_gray_capture.sv | 182 ++++++++++++++++++
 tb/tb_dvp_gray_capture.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_gray_capture.sv
// dvp_gray_capture: DVP RGB565 byte stream -> 8-bit luma with start-up frame skip.
// Optional macro TEST_PATTERN_EN adds input test_mode (gray = pixel index in line).
`default_nettype none

module dvp_gray_capture #(
  parameter int IMG_W       = 640,
  parameter int SKIP_FRAMES = 10
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic       cam_byte_en,
  input  logic [7:0] cam_data,
`ifdef TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic [7:0] gray,
  output logic       gray_valid,
  output logic       vsync_out,
  output logic       frame_err
);

  localparam int FC_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int PC_W = $clog2(IMG_W + 2);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam logic [PC_W-1:0] PC_FULL = PC_W'(IMG_W);
  localparam logic [PC_W-1:0] PC_SAT  = PC_W'(IMG_W + 1);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    SKIP    = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t          state;
  logic [FC_W-1:0] frame_cnt;
  logic            vs_d1;
  logic            vs_d2;
  logic            href_d1;
  logic            phase_low;
  logic [7:0]      hi_byte;
  logic [PC_W-1:0] pix_cnt;

  logic            s1_valid;
  logic [15:0]     s1_pr;
  logic [15:0]     s1_pg;
  logic [15:0]     s1_pb;
`ifdef TEST_PATTERN_EN
  logic            s1_test;
  logic [7:0]      s1_idx;
`endif

  logic        vs_rise;
  logic        href_fall;
  logic        accept;
  logic        pix_done;
  logic        pix_keep;
  logic        line_bad;
  logic        err_event;
  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;
  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] sum;
  logic [7:0]  luma;

  always_comb begin
    vs_rise   = cam_vsync & ~vs_d1;
    href_fall = href_d1 & ~cam_href;
    accept    = (state == ACTIVE) & cam_href & ~cam_vsync & cam_byte_en;
    pix_done  = accept & phase_low;
    pix_keep  = pix_done & (pix_cnt < PC_FULL);
    // A clean line ends with exactly IMG_W pixels and no dangling high byte.
    line_bad  = (state == ACTIVE) & href_fall & ((pix_cnt != PC_FULL) | phase_low);
    err_event = line_bad | (pix_done & ~pix_keep);

    r5 = hi_byte[7:3];
    g6 = {hi_byte[2:0], cam_data[7:5]};
    b5 = cam_data[4:0];
    r8 = {r5, r5[4:2]};
    g8 = {g6, g6[5:4]};
    b8 = {b5, b5[4:2]};

    sum  = s1_pr + s1_pg + s1_pb;
    luma = 8'(sum >> 8);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= WAIT_VS;
      frame_cnt <= '0;
    end else if (vs_rise) begin
      case (state)
        WAIT_VS: state <= (SKIP_FRAMES == 0) ? ACTIVE : SKIP;
        SKIP: begin
          frame_cnt <= frame_cnt + FC_W'(1);
          if (frame_cnt == FC_LAST) state <= ACTIVE;
        end
        ACTIVE:  state <= ACTIVE;
        default: state <= WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vs_d1     <= 1'b0;
      vs_d2     <= 1'b0;
      href_d1   <= 1'b0;
      phase_low <= 1'b0;
      hi_byte   <= 8'd0;
      pix_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      vs_d1   <= cam_vsync;
      vs_d2   <= vs_d1;
      href_d1 <= cam_href;

      if (!cam_href) begin
        phase_low <= 1'b0;
        pix_cnt   <= '0;
      end else if (accept) begin
        phase_low <= ~phase_low;
        if (!phase_low) begin
          hi_byte <= cam_data;
        end else if (pix_cnt != PC_SAT) begin
          // Saturate just past IMG_W so long lines never wrap back into range.
          pix_cnt <= pix_cnt + PC_W'(1);
        end
      end

      if (err_event) begin
        frame_err <= 1'b1;
      end else if (vs_rise) begin
        frame_err <= 1'b0;
      end
    end
  end

  assign vsync_out = vs_d2;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      s1_valid   <= 1'b0;
      s1_pr      <= 16'd0;
      s1_pg      <= 16'd0;
      s1_pb      <= 16'd0;
`ifdef TEST_PATTERN_EN
      s1_test    <= 1'b0;
      s1_idx     <= 8'd0;
`endif
      gray       <= 8'd0;
      gray_valid <= 1'b0;
    end else begin
      s1_valid <= pix_keep;
      if (pix_keep) begin
        s1_pr <= 16'(r8) * 16'd77;
        s1_pg <= 16'(g8) * 16'd150;
        s1_pb <= 16'(b8) * 16'd29;
`ifdef TEST_PATTERN_EN
        s1_test <= test_mode;
        s1_idx  <= 8'(pix_cnt);
`endif
      end

      gray_valid <= s1_valid;
      if (s1_valid) begin
`ifdef TEST_PATTERN_EN
        gray <= s1_test ? s1_idx : luma;
`else
        gray <= luma;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dvp_gray_capture.sv
// Self-checking bench for dvp_gray_capture: line/frame-level reference model plus directed literals.
`timescale 1ns/1ps
`default_nettype none

module tb_dvp_gray_capture;

  localparam int IMG_W       = 4;
  localparam int SKIP_FRAMES = 2;

  logic       sclk        = 1'b0;
  logic       s_rst_n     = 1'b1;
  logic       cam_vsync   = 1'b0;
  logic       cam_href    = 1'b0;
  logic       cam_byte_en = 1'b0;
  logic [7:0] cam_data    = 8'd0;
`ifdef TEST_PATTERN_EN
  logic       test_mode   = 1'b0;
`endif
  logic [7:0] gray;
  logic       gray_valid;
  logic       vsync_out;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  dvp_gray_capture #(
    .IMG_W       (IMG_W),
    .SKIP_FRAMES (SKIP_FRAMES)
  ) dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_byte_en (cam_byte_en),
    .cam_data    (cam_data),
`ifdef TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .gray        (gray),
    .gray_valid  (gray_valid),
    .vsync_out   (vsync_out),
    .frame_err   (frame_err)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // RGB565 -> luma straight from the colour-expansion and weighting rules.
  function automatic int luma_of(input int hi, input int lo);
    int r5, g6, b5, r8, g8, b8;
    r5 = hi / 8;
    g6 = (hi % 8) * 8 + lo / 32;
    b5 = lo % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  // Reference model: frame/line bookkeeping in byte counts, keyed by clock edge number.
  int n = 0;
  int m_edges, m_line_bytes, m_hi, m_err;
  bit m_vs_prev, m_href_prev;
  bit vh [2];
  int pend [int];

  always @(posedge sclk) begin
    bit vs_rise, href_fall, active, err_ev;
    int idx, y;
    n++;
    if (!s_rst_n) begin
      m_edges = 0; m_line_bytes = 0; m_hi = 0; m_err = 0;
      m_vs_prev = 0; m_href_prev = 0;
      vh[0] = 0; vh[1] = 0;
      pend.delete();
    end else begin
      vs_rise   = cam_vsync && !m_vs_prev;
      href_fall = m_href_prev && !cam_href;
      active    = m_edges > SKIP_FRAMES;
      err_ev    = 0;
      if (active && href_fall && m_line_bytes != 2 * IMG_W) err_ev = 1;
      if (!cam_href) begin
        m_line_bytes = 0;
      end else if (active && !cam_vsync && cam_byte_en) begin
        m_line_bytes++;
        if (m_line_bytes % 2 == 1) begin
          m_hi = int'(cam_data);
        end else begin
          idx = m_line_bytes / 2 - 1;
          if (idx < IMG_W) begin
            y = luma_of(m_hi, int'(cam_data));
`ifdef TEST_PATTERN_EN
            if (test_mode) y = idx;
`endif
            pend[n + 1] = y;
          end else begin
            err_ev = 1;
          end
        end
      end
      if (vs_rise) m_edges++;
      if (err_ev) m_err = 1;
      else if (vs_rise) m_err = 0;
      vh[0] = vh[1];
      vh[1] = cam_vsync;
      m_vs_prev   = cam_vsync;
      m_href_prev = cam_href;
    end
  end

  int last_gray = 0;
  int vcount    = 0;

  always @(negedge sclk) begin
    if (!s_rst_n) begin
      check("rst_gray", gray, 0);
      check("rst_gray_valid", gray_valid, 0);
      check("rst_vsync_out", vsync_out, 0);
      check("rst_frame_err", frame_err, 0);
      last_gray = 0;
    end else begin
      if (pend.exists(n)) begin
        check("gray_valid", gray_valid, 1);
        check("gray", gray, pend[n]);
        last_gray = pend[n];
        pend.delete(n);
      end else begin
        check("gray_valid_idle", gray_valid, 0);
        check("gray_hold", gray, last_gray);
      end
      check("vsync_out", vsync_out, vh[0]);
      check("frame_err", frame_err, m_err);
      if (gray_valid) vcount++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] lb [32];

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_byte(input logic [7:0] d);
    cam_byte_en = 1'b1;
    cam_data    = d;
    tick();
    cam_byte_en = 1'b0;
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) lb[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_line(input int nbytes, input bit gaps);
    cam_href = 1'b1;
    tick();
    for (int i = 0; i < nbytes; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_byte(lb[i]);
    end
    cam_href = 1'b0;
    tick();
    tick();
  endtask

  task automatic pix_check(input logic [7:0] hi, input logic [7:0] lo,
                           input int exp, input string name);
    send_byte(hi);
    send_byte(lo);
    tick();
    check({name, "_valid"}, gray_valid, 1);
    check(name, gray, exp);
  endtask

  task automatic random_frame(input int lines);
    vsync_pulse();
    for (int l = 0; l < lines; l++) begin
      fill_random(8);
      send_line(8, 1'b1);
    end
  endtask

  initial begin
    int v0;
    #2 s_rst_n = 1'b0;
    repeat (3) tick();
    check("reset_gray", gray, 0);
    check("reset_frame_err", frame_err, 0);
    s_rst_n = 1'b1;
    tick();

    // Start-up skip: frames 1-2 discarded, frame 3 delivers 2 x 4 pixels.
    v0 = vcount;
    random_frame(2);
    check("skip_frame1_pulses", vcount - v0, 0);
    v0 = vcount;
    random_frame(2);
    check("skip_frame2_pulses", vcount - v0, 0);
    v0 = vcount;
    random_frame(2);
    check("frame3_pulses", vcount - v0, 8);
    check("frame3_err", frame_err, 0);

    // Hand-computed luma values.
    vsync_pulse();
    cam_href = 1'b1;
    tick();
    pix_check(8'hFF, 8'hFF, 255, "luma_white");
    pix_check(8'hF8, 8'h00, 76,  "luma_red");
    pix_check(8'h07, 8'hE0, 149, "luma_green");
    pix_check(8'h00, 8'h1F, 28,  "luma_blue");
    cam_href = 1'b0;
    tick(); tick();
    cam_href = 1'b1;
    tick();
    pix_check(8'h00, 8'h00, 0, "luma_black");
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
    cam_href = 1'b0;
    tick(); tick();
    check("clean_frame_err", frame_err, 0);

    // Odd byte count: 4 pixels out, orphan dropped, error until next vsync.
    v0 = vcount;
    fill_random(9);
    send_line(9, 1'b1);
    check("odd_line_pulses", vcount - v0, 4);
    check("odd_line_err", frame_err, 1);
    cam_vsync = 1'b1;
    tick();
    check("err_cleared_by_vsync", frame_err, 0);
    repeat (2) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
    cam_href = 1'b1;
    tick();
    pix_check(8'hFF, 8'hFF, 255, "repair_pairing");
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
    cam_href = 1'b0;
    tick(); tick();
    check("repair_line_err", frame_err, 0);

    // Long line truncated, then short line in a new frame.
    v0 = vcount;
    fill_random(12);
    send_line(12, 1'b0);
    check("long_line_pulses", vcount - v0, 4);
    check("long_line_err", frame_err, 1);
    vsync_pulse();
    v0 = vcount;
    fill_random(6);
    send_line(6, 1'b1);
    check("short_line_pulses", vcount - v0, 3);
    check("short_line_err", frame_err, 1);

`ifdef TEST_PATTERN_EN
    vsync_pulse();
    test_mode = 1'b1;
    cam_href  = 1'b1;
    tick();
    for (int i = 0; i < 4; i++)
      pix_check(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i, "test_pattern");
    cam_href = 1'b0;
    tick(); tick();
    test_mode = 1'b0;
`endif

    // Randomized frames with mixed line lengths; the model checks every cycle.
    for (int f = 0; f < 6; f++) begin
      vsync_pulse();
      for (int l = 0; l < 3; l++) begin
        int nb;
        nb = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(3, 12));
        fill_random(nb);
        send_line(nb, 1'($urandom_range(0, 1)));
      end
    end

    // Asynchronous reset mid-line.
    vsync_pulse();
    cam_href = 1'b1;
    tick();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h12);
    #2 s_rst_n = 1'b0;
    #1;
    check("async_rst_gray", gray, 0);
    check("async_rst_gray_valid", gray_valid, 0);
    check("async_rst_vsync_out", vsync_out, 0);
    check("async_rst_frame_err", frame_err, 0);
    cam_href = 1'b0;
    tick(); tick();
    s_rst_n = 1'b1;
    tick();
    v0 = vcount;
    fill_random(8);
    send_line(8, 1'b0);
    check("post_rst_no_vsync_pulses", vcount - v0, 0);
    random_frame(2);
    random_frame(2);
    check("post_rst_skip_pulses", vcount - v0, 0);
    random_frame(2);
    check("post_rst_active_pulses", vcount - v0, 8);

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
